// File: rtl/uart_rx_fifo_module.sv
// UART receiver feeding a power-of-two first-word-fall-through ring buffer.
// Each stored entry carries {frame_error, parity_error, data}. The consumer pops the
// head through a valid/request handshake; overflow is sticky until the buffer is cleared.
module uart_rx_fifo_module #(
  parameter int unsigned UART_BAUD_RATE           = 9600,
  parameter int unsigned CLOCK_FREQUENCY          = 38400,
  parameter int unsigned PARITY                   = 2,  // 0 none, 1 odd, 2 even
  parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 5,
  parameter int unsigned NUMBER_STOP_BITS         = 1,
  parameter int unsigned RX_FIFO_DEEP             = 4,
  parameter int unsigned RX_FIFO_DEEP_LOG_2       = $clog2(RX_FIFO_DEEP)
) (
  input  logic                                IN_CLOCK,
  input  logic                                IN_RESET_N,
  input  logic                                RX_PORT,
  input  logic                                IN_RX_CLEAR_BUFFER,
  input  logic                                IN_RD_REQ,
  output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RD_DATA,
  output logic                                OUT_RD_PARITY_ERROR,
  output logic                                OUT_RD_FRAME_ERROR,
  output logic                                OUT_RD_VALID,
  output logic [RX_FIFO_DEEP_LOG_2:0]         OUT_RX_NUM_OF_DATA_PACKS_READY,
  output logic                                OUT_RX_OVERFLOW,
  output logic                                OUT_RX_BUSY
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned DW           = NUM_OF_DATA_BITS_IN_PACK;
  localparam int unsigned EW           = DW + 2;
  localparam int unsigned PW           = RX_FIFO_DEEP_LOG_2;
  localparam int unsigned CW           = RX_FIFO_DEEP_LOG_2 + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DW - 1);
  localparam logic [3:0]       LAST_STOP = 4'(NUMBER_STOP_BITS - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(RX_FIFO_DEEP);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StPush
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;
  logic rx_fall;

  // Two flops, both preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX_PORT;
      rx_sync_q <= rx_meta_q;
    end
  end

  // The 1->0 transition is seen as it moves from the first to the second stage, so the
  // FSM reacts on the same edge that the second stage goes low (two cycles after RX_PORT).
  assign rx_fall = rx_sync_q & ~rx_meta_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e         state_q;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic [DW-1:0]     shift_q;
  logic              par_err_q;
  logic              frm_err_q;
  logic              busy_q;
  logic              tick;

  // A sample is taken on the edge where the bit-period counter has run down to zero.
  assign tick = (clk_cnt_q == '0);

  // Frame deserialisation with registered busy flag.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_fall) begin
            state_q   <= StStart;
            clk_cnt_q <= HALF_LOAD;
            busy_q    <= 1'b1;
          end
        end

        StStart: begin
          if (tick) begin
            if (rx_sync_q) begin
              // Glitch rather than a start bit: abandon without pushing.
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= StData;
              clk_cnt_q <= FULL_LOAD;
              bit_cnt_q <= '0;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 1'b1;
          end
        end

        StData: begin
          if (tick) begin
            // LSB arrives first, so shift in from the top.
            shift_q   <= {rx_sync_q, shift_q[DW-1:1]};
            clk_cnt_q <= FULL_LOAD;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY == 0) ? StStop : StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 1'b1;
          end
        end

        StParity: begin
          if (tick) begin
            // Odd parity wants the XOR over data and parity bit to be 1, even wants 0.
            if (PARITY == 1) par_err_q <= ~(^shift_q ^ rx_sync_q);
            else             par_err_q <= ^shift_q ^ rx_sync_q;
            clk_cnt_q <= FULL_LOAD;
            state_q   <= StStop;
          end else begin
            clk_cnt_q <= clk_cnt_q - 1'b1;
          end
        end

        StStop: begin
          if (tick) begin
            if (!rx_sync_q) frm_err_q <= 1'b1;
            clk_cnt_q <= FULL_LOAD;
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              state_q   <= StPush;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 1'b1;
          end
        end

        StPush: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive ring buffer
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [RX_FIFO_DEEP];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid_q;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] wdata;
  logic          push;
  logic          pop_ok;
  logic          full;
  logic          do_write;

  assign push  = (state_q == StPush);
  assign wdata = {frm_err_q, par_err_q, shift_q};

  // Pointer/count bookkeeping and the head value that will be visible next cycle.
  always_comb begin
    pop_ok   = IN_RD_REQ && (count_q != '0);
    full     = (count_q == DEPTH_C);
    do_write = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    head_d   = '0;

    if (IN_RX_CLEAR_BUFFER) begin
      // Flush wins over any push or pop in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      // A full buffer still accepts a push when the head is leaving in the same cycle.
      do_write = push && (!full || pop_ok);
      if (push && full && !pop_ok) ovf_d = 1'b1;
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_write && !pop_ok)      count_d = count_q + 1'b1;
      else if (!do_write && pop_ok) count_d = count_q - 1'b1;
    end

    // The new head may be the entry being written this very cycle (buffer was empty,
    // or its only entry is being popped), in which case it bypasses the memory.
    if (count_d == '0)                           head_d = '0;
    else if (do_write && (rd_ptr_d == wr_ptr_q)) head_d = wdata;
    else                                         head_d = mem_q[rd_ptr_d];
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge IN_CLOCK) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers, count, sticky overflow and registered head outputs.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
    end
  end

  assign OUT_RD_DATA                    = head_q[DW-1:0];
  assign OUT_RD_PARITY_ERROR            = head_q[DW];
  assign OUT_RD_FRAME_ERROR             = head_q[DW+1];
  assign OUT_RD_VALID                   = valid_q;
  assign OUT_RX_NUM_OF_DATA_PACKS_READY = count_q;
  assign OUT_RX_OVERFLOW                = ovf_q;
  assign OUT_RX_BUSY                    = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_module.sv
// Randomised scoreboard bench for uart_rx_fifo_module (4 clocks/bit, even parity,
// 1 stop bit, 5 data bits, 4-entry buffer).
module tb_uart_rx_fifo_module;

  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [4:0] d;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr = 1'b0;
  logic       rd_req = 1'b0;
  logic [4:0] rd_data;
  logic       rd_perr;
  logic       rd_ferr;
  logic       rd_valid;
  logic [2:0] count;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int failures = 0;

  entry_t exp_q[$];
  logic   model_ovf = 1'b0;
  entry_t mon_e;

  uart_rx_fifo_module #(
    .UART_BAUD_RATE          (9600),
    .CLOCK_FREQUENCY         (38400),
    .PARITY                  (2),
    .NUM_OF_DATA_BITS_IN_PACK(5),
    .NUMBER_STOP_BITS        (1),
    .RX_FIFO_DEEP            (4)
  ) dut (
    .IN_CLOCK                      (clk),
    .IN_RESET_N                    (rst_n),
    .RX_PORT                       (rx),
    .IN_RX_CLEAR_BUFFER            (clr),
    .IN_RD_REQ                     (rd_req),
    .OUT_RD_DATA                   (rd_data),
    .OUT_RD_PARITY_ERROR           (rd_perr),
    .OUT_RD_FRAME_ERROR            (rd_ferr),
    .OUT_RD_VALID                  (rd_valid),
    .OUT_RX_NUM_OF_DATA_PACKS_READY(count),
    .OUT_RX_OVERFLOW               (ovf),
    .OUT_RX_BUSY                   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #(600_000);
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rd_req && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_valid", 32'(rd_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_entry", 32'({rd_ferr, rd_perr, rd_data}), 32'(mon_e));
      end
    end
  end

  // Compare the visible buffer state with the model.
  task automatic check_state(input string tag);
    entry_t h;
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    check({tag, "_overflow"}, 32'(ovf), 32'(model_ovf));
    if (exp_q.size() != 0) h = exp_q[0];
    else                   h = '0;
    check({tag, "_head"}, 32'({rd_ferr, rd_perr, rd_data}), 32'(h));
  endtask

  // Serialise one frame; mode 1 raises rd_req and mode 2 raises clear in the push cycle.
  task automatic send_frame(input logic [4:0] d, input logic pbit, input logic stop,
                            input int mode);
    logic [7:0] bits;
    entry_t     e;
    bits = {stop, pbit, d, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      rx = bits[k];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (mode == 1) rd_req = 1'b1;
    if (mode == 2) clr = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e.d  = d;
    e.pe = pbit ^ (^d);
    e.fe = ~stop;
    if (mode == 2) begin
      exp_q.delete();
      model_ovf = 1'b0;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(e);
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic send_good(input logic [4:0] d);
    send_frame(d, ^d, 1'b1, 0);
  endtask

  task automatic read_n(input int n);
    @(posedge clk); #1;
    rd_req = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n = 0;
    while (busy !== val && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  initial begin
    logic [4:0] rd;
    logic       pinj;
    logic       finj;
    int         md;

    // Reset values
    #12;
    check("reset_data", 32'(rd_data), 32'd0);
    check("reset_perr", 32'(rd_perr), 32'd0);
    check("reset_ferr", 32'(rd_ferr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check_state("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Nominal frame then single pop
    send_frame(5'b01010, 1'b0, 1'b1, 0);
    check_state("nominal");
    read_n(1);
    check_state("nominal_pop");

    // Error tagging
    send_frame(5'b01010, 1'b1, 1'b1, 0);
    check("perr_flag", 32'(rd_perr), 32'd1);
    check_state("perr");
    read_n(1);
    send_frame(5'b00111, 1'b1, 1'b0, 0);
    check("ferr_flag", 32'(rd_ferr), 32'd1);
    check_state("ferr");
    read_n(1);

    // Overflow and pointer wrap
    for (int i = 1; i <= 5; i++) send_good(5'(i));
    check_state("overflow");
    read_n(4);
    check_state("drained");
    send_good(5'd6);
    send_good(5'd7);
    check_state("wrap");
    read_n(2);
    pulse_clear();
    check_state("clear");

    // Push and pop together while full
    for (int i = 0; i < 4; i++) send_good(5'(8 + i));
    send_frame(5'd20, ^5'd20, 1'b1, 1);
    check_state("full_push_pop");
    // Clear together with push
    send_frame(5'd21, ^5'd21, 1'b1, 2);
    check_state("clear_in_push");

    // False start with an entry present
    send_good(5'd3);
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    wait_busy(1'b1, 6, "false_start_busy_hi");
    wait_busy(1'b0, 8, "false_start_busy_lo");
    repeat (4) @(posedge clk);
    #1;
    check_state("false_start");

    // Reset during data bit 2
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_ovf = 1'b0;
    check("midreset_data", 32'(rd_data), 32'd0);
    check("midreset_perr", 32'(rd_perr), 32'd0);
    check("midreset_ferr", 32'(rd_ferr), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check_state("midreset");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_good(5'b10001);
    check_state("after_reset");
    read_n(1);

    // Randomised traffic
    for (int it = 0; it < 30; it++) begin
      rd   = 5'($urandom);
      pinj = ($urandom_range(0, 3) == 0);
      finj = ($urandom_range(0, 4) == 0);
      md   = $urandom_range(0, 7);
      md   = (md == 6) ? 1 : (md == 7) ? 2 : 0;
      send_frame(rd, (^rd) ^ pinj, ~finj, md);
      if ($urandom_range(0, 2) == 0) read_n($urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) pulse_clear();
      check_state("random");
    end
    read_n(DEPTH + 1);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
